com_host_controller: RTL and testbench

//  Host-side initiator for the com port of the data-memory selector.

---
 rtl/com_host_controller.sv | 166 ++++++++++++++++
 tb/tb_com_host_controller.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/com_host_controller.sv
// Host-side com port initiator: streams a block into data memory, starts the cores,
// waits for end_process, then streams a result block back out.
module com_host_controller #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int RUN_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W-1:0] load_count,
  input  logic [ADDR_W-1:0] unload_base,
  input  logic [ADDR_W-1:0] unload_count,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        status,
  output logic [DATA_W-1:0] com_data_in,
  output logic [ADDR_W-1:0] com_addr,
  output logic              com_wr_en,
  input  logic [DATA_W-1:0] com_data_out,
  input  logic              end_process,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LOAD_FLUSH, S_RUN, S_RD_ADDR, S_RD_WAIT, S_RD_OUT, S_DONE
  } state_t;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_LOAD   = 2'b01;
  localparam logic [1:0] ST_RUN    = 2'b10;
  localparam logic [1:0] ST_UNLOAD = 2'b11;

  state_t            state_reg;
  logic [ADDR_W-1:0] load_base_reg;
  logic [ADDR_W-1:0] load_count_reg;
  logic [ADDR_W-1:0] unload_base_reg;
  logic [ADDR_W-1:0] unload_count_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic [31:0]       run_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= S_IDLE;
      load_base_reg    <= '0;
      load_count_reg   <= '0;
      unload_base_reg  <= '0;
      unload_count_reg <= '0;
      idx_reg          <= '0;
      run_cnt_reg      <= '0;
      in_ready         <= 1'b0;
      out_data         <= '0;
      out_valid        <= 1'b0;
      status           <= ST_IDLE;
      com_data_in      <= '0;
      com_addr         <= '0;
      com_wr_en        <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      timeout          <= 1'b0;
    end else begin
      done      <= 1'b0;
      com_wr_en <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            load_base_reg    <= load_base;
            load_count_reg   <= load_count;
            unload_base_reg  <= unload_base;
            unload_count_reg <= unload_count;
            idx_reg          <= '0;
            timeout          <= 1'b0;
            busy             <= 1'b1;
            if (load_count != '0) begin
              state_reg <= S_LOAD;
              status    <= ST_LOAD;
              in_ready  <= 1'b1;
            end else begin
              state_reg   <= S_RUN;
              status      <= ST_RUN;
              run_cnt_reg <= '0;
            end
          end
        end
        S_LOAD: begin
          // Each accepted word becomes one write strobe on the following cycle.
          if (in_valid && in_ready) begin
            com_data_in <= in_data;
            com_addr    <= load_base_reg + idx_reg;
            com_wr_en   <= 1'b1;
            idx_reg     <= idx_reg + 1'b1;
            if (idx_reg == load_count_reg - 1'b1) begin
              state_reg <= S_LOAD_FLUSH;
              in_ready  <= 1'b0;
            end
          end
        end
        S_LOAD_FLUSH: begin
          state_reg   <= S_RUN;
          status      <= ST_RUN;
          run_cnt_reg <= '0;
        end
        S_RUN: begin
          if (run_cnt_reg != '1) run_cnt_reg <= run_cnt_reg + 1'b1;
          // The first two RUN cycles may still see end_process from the previous job.
          if (run_cnt_reg >= 32'd2 && end_process) begin
            if (unload_count_reg != '0) begin
              state_reg <= S_RD_ADDR;
              status    <= ST_UNLOAD;
              idx_reg   <= '0;
              com_addr  <= unload_base_reg;
            end else begin
              state_reg <= S_DONE;
              status    <= ST_IDLE;
              done      <= 1'b1;
            end
          end else if (RUN_TIMEOUT != 0 && run_cnt_reg == 32'(RUN_TIMEOUT - 1)) begin
            state_reg <= S_DONE;
            status    <= ST_IDLE;
            done      <= 1'b1;
            timeout   <= 1'b1;
          end
        end
        S_RD_ADDR: state_reg <= S_RD_WAIT;
        S_RD_WAIT: begin
          out_data  <= com_data_out;
          out_valid <= 1'b1;
          state_reg <= S_RD_OUT;
        end
        S_RD_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx_reg == unload_count_reg - 1'b1) begin
              state_reg <= S_DONE;
              status    <= ST_IDLE;
              done      <= 1'b1;
            end else begin
              idx_reg   <= idx_reg + 1'b1;
              com_addr  <= unload_base_reg + idx_reg + 1'b1;
              state_reg <= S_RD_ADDR;
            end
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= S_IDLE;
          status    <= ST_IDLE;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_com_host_controller.sv
// Bench for com_host_controller: directed jobs with a memory model, a write/stream
// scoreboard and per-cycle protocol rules, plus hand-computed timing checks.
module tb_com_host_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] load_base, load_count, unload_base, unload_count;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  status;
  logic [15:0] com_data_in;
  logic [15:0] com_addr;
  logic        com_wr_en;
  logic [15:0] com_data_out;
  logic        end_process;
  logic        busy, done, timeout;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  logic [15:0] exp_wr_addr[$];
  logic [15:0] exp_wr_data[$];
  logic [15:0] exp_out[$];

  logic        prev_ov, prev_or;
  logic [15:0] prev_od;

  logic        pre_en;
  logic [15:0] pre_addr, pre_data;
  logic [15:0] mem [0:65535];

  always #5 clk = ~clk;

  com_host_controller #(.DATA_W(16), .ADDR_W(16), .RUN_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .load_base(load_base), .load_count(load_count),
    .unload_base(unload_base), .unload_count(unload_count),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .status(status), .com_data_in(com_data_in), .com_addr(com_addr),
    .com_wr_en(com_wr_en), .com_data_out(com_data_out),
    .end_process(end_process), .busy(busy), .done(done), .timeout(timeout)
  );

  // Data memory seen through the selector: synchronous write, one-cycle read latency.
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (com_wr_en) mem[com_addr] <= com_data_in;
    com_data_out <= mem[com_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic note_fail(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: got unexpected transfer, expected none at %0t", nm, $time);
  endtask

  // Per-cycle rules and the write/stream scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy_rule", busy, (status != 2'b00) || done);
      if (in_ready) chk("in_ready_status", status, 2'b01);
      if (com_wr_en) begin
        chk("wr_status", status, 2'b01);
        if (exp_wr_addr.size() == 0) note_fail("wr_unexpected");
        else begin
          chk("wr_addr", com_addr, exp_wr_addr[0]);
          chk("wr_data", com_data_in, exp_wr_data[0]);
          exp_wr_addr.delete(0);
          exp_wr_data.delete(0);
        end
      end
      if (prev_ov && !prev_or) begin
        chk("out_hold_valid", out_valid, 1'b1);
        chk("out_hold_data", out_data, prev_od);
      end
      if (out_valid) begin
        chk("out_status", status, 2'b11);
        if (out_ready) begin
          if (exp_out.size() == 0) note_fail("out_unexpected");
          else begin
            chk("out_word", out_data, exp_out[0]);
            exp_out.delete(0);
          end
        end
      end
      if (done) done_cnt <= done_cnt + 1;
      prev_ov <= out_valid;
      prev_or <= out_ready;
      prev_od <= out_data;
    end else begin
      prev_ov <= 1'b0;
      prev_or <= 1'b0;
      prev_od <= '0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] lb, lc, ub, uc);
    load_base = lb; load_count = lc; unload_base = ub; unload_count = uc;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000ns");
    $fatal(1);
  end

  initial begin
    logic [15:0] words [3];
    words[0] = 16'h00A1; words[1] = 16'h00B2; words[2] = 16'h00C3;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    end_process = 1'b0; load_base = '0; load_count = '0; unload_base = '0; unload_count = '0;
    pre_en = 1'b1; pre_addr = 16'h0020; pre_data = 16'd7;
    step();
    pre_addr = 16'h0021; pre_data = 16'd9;
    step();
    pre_en = 1'b0;
    chk("rst_status", status, 2'b00);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_wr_en", com_wr_en, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    step(); step();

    // T1: asynchronous reset in the middle of LOAD
    start_job(16'h0040, 16'd3, 16'h0000, 16'd0);
    chk("t1_status_load", status, 2'b01);
    in_valid = 1'b1; in_data = 16'h0055;
    step();
    in_valid = 1'b0;
    chk("t1_wr_pulse", com_wr_en, 1'b1);
    chk("t1_wr_addr", com_addr, 16'h0040);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_status", status, 2'b00);
    chk("t1_wr_en", com_wr_en, 1'b0);
    chk("t1_in_ready", in_ready, 1'b0);
    chk("t1_busy", busy, 1'b0);
    step();
    rst_n = 1'b1;
    step(); step();

    // T2/T3: load three words with gaps, run, unload two words with back-pressure
    for (int k = 0; k < 3; k++) begin
      exp_wr_addr.push_back(16'h0010 + 16'(k));
      exp_wr_data.push_back(words[k]);
    end
    exp_out.push_back(16'd7);
    exp_out.push_back(16'd9);
    start_job(16'h0010, 16'd3, 16'h0020, 16'd2);
    chk("t2_status_load", status, 2'b01);
    chk("t2_in_ready", in_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      in_valid = 1'b1; in_data = words[k];
      step();
      in_valid = 1'b0;
    end
    chk("t2_flush_status", status, 2'b01);
    chk("t2_flush_in_ready", in_ready, 1'b0);
    chk("t2_flush_wr_en", com_wr_en, 1'b1);
    chk("t2_flush_addr", com_addr, 16'h0012);
    step();
    chk("t2_run_status", status, 2'b10);
    chk("t2_run_wr_en", com_wr_en, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      step();
      chk("t3_run_hold", status, 2'b10);
    end
    end_process = 1'b1;
    step();
    end_process = 1'b0;
    chk("t3_unload_status", status, 2'b11);
    chk("t3_rd_addr0", com_addr, 16'h0020);
    chk("t3_no_valid_addr", out_valid, 1'b0);
    step();
    chk("t3_no_valid_wait", out_valid, 1'b0);
    step();
    chk("t3_valid0", out_valid, 1'b1);
    chk("t3_data0", out_data, 16'd7);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t3_stall_data", out_data, 16'd7);
    end
    out_ready = 1'b1;
    step();
    chk("t3_valid_drop", out_valid, 1'b0);
    chk("t3_rd_addr1", com_addr, 16'h0021);
    step(); step();
    chk("t3_data1", out_data, 16'd9);
    step();
    out_ready = 1'b0;
    chk("t3_done", done, 1'b1);
    chk("t3_done_status", status, 2'b00);
    chk("t3_done_busy", busy, 1'b1);
    chk("t3_no_timeout", timeout, 1'b0);
    step();
    chk("t3_done_pulse", done, 1'b0);
    chk("t3_idle_busy", busy, 1'b0);
    chk("t3_done_count", done_cnt, 1);
    chk("t3_out_left", exp_out.size(), 0);
    chk("t2_wr_left", exp_wr_addr.size(), 0);

    // T4: zero counts, end_process already high -> guard holds RUN for cycles 0..2
    start_job(16'h0000, 16'd0, 16'h0000, 16'd0);
    chk("t4_run_status", status, 2'b10);
    chk("t4_in_ready", in_ready, 1'b0);
    end_process = 1'b1;
    step();
    chk("t4_guard1", status, 2'b10);
    step();
    chk("t4_guard2", status, 2'b10);
    step();
    end_process = 1'b0;
    chk("t4_done", done, 1'b1);
    chk("t4_status", status, 2'b00);
    step();
    chk("t4_done_count", done_cnt, 2);

    // T5: timeout after 8 RUN cycles, no unload
    start_job(16'h0000, 16'd0, 16'h0030, 16'd2);
    step_n(7);
    chk("t5_run7_status", status, 2'b10);
    chk("t5_run7_done", done, 1'b0);
    step();
    chk("t5_done", done, 1'b1);
    chk("t5_timeout", timeout, 1'b1);
    chk("t5_status", status, 2'b00);
    step();
    chk("t5_timeout_held", timeout, 1'b1);
    chk("t5_done_pulse", done, 1'b0);
    chk("t5_done_count", done_cnt, 3);

    // T6: address wrap, back-to-back loads, stale end_process on RUN entry
    exp_wr_addr.push_back(16'hFFFF); exp_wr_data.push_back(16'h1234);
    exp_wr_addr.push_back(16'h0000); exp_wr_data.push_back(16'h5678);
    exp_out.push_back(16'h1234);
    end_process = 1'b1;
    start_job(16'hFFFF, 16'd2, 16'hFFFF, 16'd1);
    chk("t6_timeout_cleared", timeout, 1'b0);
    chk("t6_status_load", status, 2'b01);
    in_valid = 1'b1; in_data = 16'h1234;
    step();
    chk("t6_wr_addr0", com_addr, 16'hFFFF);
    in_data = 16'h5678;
    step();
    in_valid = 1'b0;
    chk("t6_wr_addr1", com_addr, 16'h0000);
    chk("t6_flush_wr_en", com_wr_en, 1'b1);
    step();
    chk("t6_run0", status, 2'b10);
    step();
    chk("t6_run1", status, 2'b10);
    step();
    chk("t6_run2", status, 2'b10);
    step();
    end_process = 1'b0;
    out_ready = 1'b1;
    chk("t6_unload_status", status, 2'b11);
    chk("t6_rd_addr", com_addr, 16'hFFFF);
    step(); step();
    chk("t6_data", out_data, 16'h1234);
    step();
    out_ready = 1'b0;
    chk("t6_done", done, 1'b1);
    step();
    chk("t6_done_count", done_cnt, 4);
    chk("t6_out_left", exp_out.size(), 0);
    chk("t6_wr_left", exp_wr_addr.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

endmodule
